screen_fb_writer: RTL and testbench
===================================

// Module: screen_fb_writer
// PURPOSE
//  Write side of the double-buffered framebuffer scanned by screen32x32.
//  - Takes pixel writes from the rv32i bus peripheral over a valid/ready handshake.
//  - Drives the framebuffer RAM write port; screen32x32 reads the other bank.
//  - Provides a hardware fill engine.
//  - Swaps the displayed bank only at end of frame, so no tearing is visible.
// PARAMETERS
//  X_W    5  column index width; panel width = 2**X_W
//  Y_W    5  row index width; panel height = 2**Y_W
//  PIX_W  3  pixel width, {r,g,b}
//  Derived: AW = X_W+Y_W; RAM address width = AW+1 (bank bit is the MSB).
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-low reset
//  wr_valid      in   1      pixel write request
//  wr_ready      out  1      write accepted when wr_valid & wr_ready
//  wr_x          in   X_W    column
//  wr_y          in   Y_W    row
//  wr_pix        in   PIX_W  pixel value
//  fill_start    in   1      one-cycle pulse: fill back bank with fill_pix
//  fill_pix      in   PIX_W  fill value, sampled with fill_start
//  swap_req      in   1      one-cycle pulse: request a bank swap
//  frame_end     in   1      one-cycle pulse from screen32x32, last row scanned
//  fb_we         out  1      RAM write enable
//  fb_waddr      out  AW+1   RAM write address {bank, y, x}
//  fb_wdata      out  PIX_W  RAM write data
//  rd_bank       out  1      bank screen32x32 displays; back bank = ~rd_bank
//  swap_pending  out  1      swap requested, not yet performed
//  busy          out  1      fill in progress
// BEHAVIOUR
//  Reset (reset==0 at posedge clk): state IDLE. These outputs are 0:
//   fb_we, fb_waddr, fb_wdata, rd_bank, swap_pending, busy.
//   wr_ready is forced 0 while reset is low.
//  States: IDLE, FILL.
//  wr_ready = reset & (state==IDLE) & ~fill_start. This is combinational.
//  Write latency is 1 cycle. A handshake in cycle N gives, in cycle N+1:
//   fb_we=1, fb_waddr={~rd_bank,wr_y,wr_x}, fb_wdata=wr_pix.
//   Back-to-back writes run at 1 per cycle.
//  The bank bit is taken from rd_bank in the handshake cycle.
//  IDLE->FILL on fill_start. fill_start has priority over a same-cycle wr_valid,
//   so that write is not accepted.
//  FILL: latches fill_pix and the back bank at start.
//   - Issues 2**AW consecutive writes, x fastest, from address 0 to 2**AW-1.
//   - The first write is the cycle after fill_start.
//   - busy is 1 from that cycle through the last write.
//   - FILL->IDLE after the last write.
//   - fill_start received during FILL is ignored.
//  Swap handling:
//   - swap_req sets swap_pending.
//   - On frame_end with pending (or with swap_req in the same cycle) and state IDLE:
//     rd_bank toggles and swap_pending clears on the next edge.
//   - frame_end during FILL does not swap; pending is kept for the next frame_end.
//   - swap_req while already pending has no extra effect.
//   - A write accepted in the same cycle as the swap edge uses the pre-swap back bank.
//  Reset mid-fill aborts immediately. The RAM contents are left as-is.
// CONFIGURATION
//  SCREEN_FB_FILL_EN defined:
//   - FILL state, fill counter and busy are built as described above.
//  Not defined:
//   - No FILL state; fill_start and fill_pix are ignored.
//   - busy is tied to 0; wr_ready = reset & ~0 (always 1 out of reset).
//   - Swaps are never deferred.
// TESTING
//  1. Reset, then write x=3,y=2,pix=5 -> next cycle fb_we=1, fb_waddr=0x443, fb_wdata=5.
//  2. swap_req, then frame_end 10 cycles later -> swap_pending=1 until frame_end;
//     then rd_bank=1, swap_pending=0. Next write x=0,y=0 -> fb_waddr=0x000.
//  3. fill_start with fill_pix=7 -> exactly 1024 fb_we cycles, addresses 0x400..0x7FF
//     with data 7, then busy=0. Same-cycle wr_valid is refused; wr_ready=0 throughout.
//  4. swap_req plus frame_end at fill cycle 100 -> rd_bank stays 0. Swap happens on the
//     first frame_end after busy falls.
//  5. reset=0 at fill cycle 500 -> next cycle fb_we=0, busy=0, rd_bank=0, wr_ready=0.
//  6. Build without SCREEN_FB_FILL_EN, pulse fill_start -> no fb_we, busy stays 0,
//     wr_ready stays 1.

Source files
------------

// File: rtl/screen_fb_writer.sv
// rtl/screen_fb_writer.sv - double-buffered framebuffer write port with fill engine and frame-synchronous bank swap
// Optional fill engine: define SCREEN_FB_FILL_EN to build the FILL state, fill counter and busy.
module screen_fb_writer #(
  parameter int X_W   = 5,
  parameter int Y_W   = 5,
  parameter int PIX_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [X_W-1:0]       wr_x,
  input  logic [Y_W-1:0]       wr_y,
  input  logic [PIX_W-1:0]     wr_pix,
  input  logic                 fill_start,
  input  logic [PIX_W-1:0]     fill_pix,
  input  logic                 swap_req,
  input  logic                 frame_end,
  output logic                 fb_we,
  output logic [X_W+Y_W:0]     fb_waddr,
  output logic [PIX_W-1:0]     fb_wdata,
  output logic                 rd_bank,
  output logic                 swap_pending,
  output logic                 busy
);

  localparam int AW = X_W + Y_W;

  logic          idle;
  logic          fill_go;
  logic          fill_step;
  logic [AW-1:0] fill_next;
  logic          wr_fire;
  logic          swap_now;

`ifdef SCREEN_FB_FILL_EN
  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] fill_cnt;
  logic          fill_last;

  assign idle      = (state == S_IDLE);
  assign fill_last = (fill_cnt == {AW{1'b1}});
  assign fill_go   = idle & fill_start;
  assign fill_step = (state == S_FILL) & ~fill_last;
  assign fill_next = fill_cnt + AW'(1);
  assign busy      = (state == S_FILL);
  assign wr_ready  = reset & idle & ~fill_start;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (fill_start) state_nxt = S_FILL;
      S_FILL: if (fill_last)  state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // fill_cnt tracks the address currently presented on the write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      fill_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (fill_go)
        fill_cnt <= '0;
      else if (fill_step)
        fill_cnt <= fill_next;
    end
  end
`else
  logic unused_fill;

  assign unused_fill = fill_start;
  assign idle        = 1'b1;
  assign fill_go     = 1'b0;
  assign fill_step   = 1'b0;
  assign fill_next   = '0;
  assign busy        = 1'b0;
  assign wr_ready    = reset;
`endif

  assign wr_fire  = wr_valid & wr_ready;
  // swap_req in the frame_end cycle counts as pending; never swap mid-fill
  assign swap_now = frame_end & (swap_pending | swap_req) & idle;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_bank      <= 1'b0;
      swap_pending <= 1'b0;
    end else if (swap_now) begin
      rd_bank      <= ~rd_bank;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  // Bank bit is taken from the pre-swap rd_bank, so a write or fill that
  // coincides with a swap edge still lands in the old back bank.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
    end else if (fill_go) begin
      fb_we    <= 1'b1;
      fb_waddr <= {~rd_bank, {AW{1'b0}}};
      fb_wdata <= fill_pix;
    end else if (fill_step) begin
      fb_we    <= 1'b1;
      fb_waddr <= {fb_waddr[AW], fill_next};
    end else if (wr_fire) begin
      fb_we    <= 1'b1;
      fb_waddr <= {~rd_bank, wr_y, wr_x};
      fb_wdata <= wr_pix;
    end else begin
      fb_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_screen_fb_writer.sv
// tb/tb_screen_fb_writer.sv - scoreboard bench for screen_fb_writer
module tb_screen_fb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_x;
  logic [4:0]  wr_y;
  logic [2:0]  wr_pix;
  logic        fill_start;
  logic [2:0]  fill_pix;
  logic        swap_req;
  logic        frame_end;
  logic        fb_we;
  logic [10:0] fb_waddr;
  logic [2:0]  fb_wdata;
  logic        rd_bank;
  logic        swap_pending;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  logic        exp_bank = 1'b0;

  screen_fb_writer #(.X_W(5), .Y_W(5), .PIX_W(3)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_pix(wr_pix),
    .fill_start(fill_start), .fill_pix(fill_pix),
    .swap_req(swap_req), .frame_end(frame_end),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
    .rd_bank(rd_bank), .swap_pending(swap_pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one write handshake; wr_ready is 1 whenever this is used
  task automatic wr(input logic [4:0] x, input logic [4:0] y, input logic [2:0] p);
    wr_valid = 1'b1; wr_x = x; wr_y = y; wr_pix = p;
    exp_q.push_back({~exp_bank, y, x, p});
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic push_fill(input logic bank, input logic [2:0] p);
    for (int i = 0; i < 1024; i++)
      exp_q.push_back({bank, 10'(i), p});
  endtask

  // monitor: every RAM write must match the head of the expected queue
  always @(negedge clk) begin
    if (fb_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=0x%0h/%0d expected=none", fb_waddr, fb_wdata);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(fb_waddr), 32'(e[13:3]));
        chk("write_data", 32'(fb_wdata), 32'(e[2:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_pix = '0;
    fill_start = 1'b0; fill_pix = '0; swap_req = 1'b0; frame_end = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_fb_waddr", 32'(fb_waddr), 0);
    chk("rst_fb_wdata", 32'(fb_wdata), 0);
    chk("rst_rd_bank", 32'(rd_bank), 0);
    chk("rst_swap_pending", 32'(swap_pending), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    step(1);
    reset = 1'b1;
    #2;
    chk("wr_ready_out_of_reset", 32'(wr_ready), 1);
    step(1);

    // single write, one-cycle latency, bank 1 while displaying bank 0
    wr(5'd3, 5'd2, 3'd5);
    @(negedge clk);
    chk("t1_fb_we", 32'(fb_we), 1);
    chk("t1_fb_waddr", 32'(fb_waddr), 32'h443);
    chk("t1_fb_wdata", 32'(fb_wdata), 5);
    step(1);

    // swap deferred to frame_end
    swap_req = 1'b1; step(1); swap_req = 1'b0;
    step(9);
    @(negedge clk);
    chk("t2_pending_before", 32'(swap_pending), 1);
    chk("t2_bank_before", 32'(rd_bank), 0);
    step(1);
    frame_end = 1'b1; step(1); frame_end = 1'b0;
    exp_bank = 1'b1;
    @(negedge clk);
    chk("t2_bank_after", 32'(rd_bank), 1);
    chk("t2_pending_after", 32'(swap_pending), 0);
    step(1);
    wr(5'd0, 5'd0, 3'd2);
    @(negedge clk);
    chk("t2_fb_waddr", 32'(fb_waddr), 32'h000);
    step(1);

    // back-to-back writes, the last one on the swap edge uses the old back bank
    wr(5'd31, 5'd31, 3'd1);
    wr(5'd1, 5'd30, 3'd6);
    swap_req = 1'b1; frame_end = 1'b1;
    wr(5'd7, 5'd9, 3'd3);
    swap_req = 1'b0; frame_end = 1'b0;
    exp_bank = 1'b0;
    @(negedge clk);
    chk("swap_edge_waddr", 32'(fb_waddr), 32'h127);
    chk("swap_edge_bank", 32'(rd_bank), 0);
    step(2);
    chk("queue_drained_writes", 32'(exp_q.size()), 0);

`ifdef SCREEN_FB_FILL_EN
    begin
      int busy_cycles;
      int n;
      // full fill of bank 1, refusing a same-cycle write, ignoring a re-start
      fill_start = 1'b1; fill_pix = 3'd7;
      wr_valid = 1'b1; wr_x = 5'd4; wr_y = 5'd4; wr_pix = 3'd2;
      #2;
      chk("t3_ready_on_fill_start", 32'(wr_ready), 0);
      push_fill(1'b1, 3'd7);
      step(1);
      fill_start = 1'b0;
      busy_cycles = 0;
      n = 0;
      while (n < 1100) begin
        @(negedge clk);
        if (!busy) break;
        busy_cycles++;
        chk("t3_ready_during_fill", 32'(wr_ready), 0);
        if (busy_cycles == 10) begin
          #1 fill_start = 1'b1; fill_pix = 3'd3;
        end else begin
          #1 fill_start = 1'b0;
        end
        n++;
      end
      wr_valid = 1'b0; fill_start = 1'b0;
      chk("t3_busy_cycles", 32'(busy_cycles), 1024);
      chk("t3_queue_empty", 32'(exp_q.size()), 0);
      chk("t3_ready_after", 32'(wr_ready), 1);
      step(1);

      // swap during fill is deferred to the first frame_end after busy falls
      fill_start = 1'b1; fill_pix = 3'd4;
      push_fill(1'b1, 3'd4);
      step(1);
      fill_start = 1'b0;
      step(99);
      swap_req = 1'b1; frame_end = 1'b1; step(1);
      swap_req = 1'b0; frame_end = 1'b0;
      @(negedge clk);
      chk("t4_bank_in_fill", 32'(rd_bank), 0);
      chk("t4_pending_in_fill", 32'(swap_pending), 1);
      n = 0;
      while (busy && n < 1100) begin
        @(negedge clk);
        n++;
      end
      chk("t4_busy_fell", 32'(busy), 0);
      chk("t4_bank_after_fill", 32'(rd_bank), 0);
      step(3);
      frame_end = 1'b1; step(1); frame_end = 1'b0;
      exp_bank = 1'b1;
      @(negedge clk);
      chk("t4_bank_swapped", 32'(rd_bank), 1);
      chk("t4_pending_cleared", 32'(swap_pending), 0);
      chk("t4_queue_empty", 32'(exp_q.size()), 0);
      step(1);

      // reset mid-fill aborts at once
      fill_start = 1'b1; fill_pix = 3'd1;
      push_fill(1'b0, 3'd1);
      step(1);
      fill_start = 1'b0;
      step(499);
      reset = 1'b0;
      step(1);
      exp_q.delete();
      exp_bank = 1'b0;
      @(negedge clk);
      chk("t5_fb_we", 32'(fb_we), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_rd_bank", 32'(rd_bank), 0);
      chk("t5_wr_ready", 32'(wr_ready), 0);
      step(1);
      reset = 1'b1;
      step(1);
      wr(5'd2, 5'd1, 3'd6);
      @(negedge clk);
      chk("t5_write_after_reset", 32'(fb_waddr), 32'h422);
      step(1);
    end
`else
    // fill engine absent: fill_start has no effect
    fill_start = 1'b1; fill_pix = 3'd7;
    #2;
    chk("t6_ready_on_fill_start", 32'(wr_ready), 1);
    step(1);
    fill_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t6_fb_we", 32'(fb_we), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_wr_ready", 32'(wr_ready), 1);
    end
    step(1);
`endif

    step(3);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
